// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage MIPS32 pipeline
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_dst,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] S_HOLD     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  localparam logic [3:0] HOLD_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT);

  logic [1:0] state;
  logic [3:0] hold_cnt;
  logic [7:0] wait_cnt;

  logic load_use;
  logic freeze_run;
  logic wait_done;
  logic frozen;

  always_comb begin
    load_use   = ex_memread && (ex_dst != 5'd0) &&
                 ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
    freeze_run = (state == S_RUN) && mem_req && !dmem_ack;
    wait_done  = dmem_ack || (wait_cnt == WAIT_LAST);
    frozen     = freeze_run || ((state == S_MEM_WAIT) && !wait_done);
  end

  always_comb begin
    pc_we        = 1'b1;
    pc_sel       = 2'd0;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_we     = 1'b1;
    memwb_bubble = 1'b0;
    busy         = (state != S_RUN);
    if (reset || (state != S_RUN && state != S_MEM_WAIT)) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
      busy         = 1'b1;
    end else if (frozen) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      pc_sel      = 2'd1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      // A jump sitting in ID waits here and resolves once the lw leaves EX.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_jump) begin
      pc_sel     = 2'd2;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_HOLD;
      hold_cnt  <= 4'd0;
      wait_cnt  <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= S_RUN;
            hold_cnt <= 4'd0;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        S_RUN: begin
          if (freeze_run) begin
            state    <= S_MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_ack) begin
            state    <= S_RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            mem_err  <= 1'b1;
            state    <= S_RUN;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_HOLD;
      endcase
      if ((state == S_RUN || state == S_MEM_WAIT) && !pc_we && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS32 pipeline. It sits beside the opcode decoder and drives the write-enable, flush and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, taken beq in EX, j/jal in ID, and multi-cycle data-memory waits. It also sequences the post-reset pipeline flush.

Parameters:
FLUSH_CYCLES, 3, cycles spent in HOLD after reset deasserts (range 1..15)
MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before forced release (range 1..255)
CNT_W, 16, width of the stall_cnt counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
id_jump  in  1  decoder Jump for ID instruction (j/jal)
ex_memread  in  1  EX instruction is lw
ex_dst  in  5  destination register of EX instruction
ex_branch_taken  in  1  beq in EX resolved taken
mem_req  in  1  MEM stage performing lw/sw this cycle
dmem_ack  in  1  data memory completes access this cycle
pc_we  out  1  PC update enable
pc_sel  out  2  0=PC+4, 1=branch target, 2=jump target
ifid_we  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID load NOP
idex_we  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX load all-zero controls
exmem_we  out  1  EX/MEM load enable
memwb_bubble  out  1  MEM/WB load all-zero controls
busy  out  1  state != RUN
mem_err  out  1  sticky flag: memory timeout occurred
stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0 in RUN/MEM_WAIT

Behaviour:
- The control outputs are combinational from state and inputs. hold_cnt, wait_cnt, mem_err and stall_cnt are registered.
- Reset (reset=1, combinational override): pc_we=0, ifid_we=0, idex_we=0, exmem_we=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1, pc_sel=0, busy=1. At the edge: state<=HOLD, hold_cnt<=0, wait_cnt<=0, mem_err<=0, stall_cnt<=0.
- States: HOLD, RUN, MEM_WAIT.
- HOLD: outputs equal the reset values; hold_cnt increments each cycle; at hold_cnt==FLUSH_CYCLES-1 go to RUN. So exactly FLUSH_CYCLES HOLD cycles follow reset deassertion.
- RUN default: all *_we=1, flush/bubble=0, pc_sel=0.
- RUN priority, highest first:
  1. mem_req && !dmem_ack: freeze. pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1, all other events ignored. Next state MEM_WAIT, wait_cnt<=1.
  2. ex_branch_taken: pc_sel=1, pc_we=1, ifid_flush=1, idex_bubble=1. This overrides load-use and jump.
  3. Load-use: ex_memread && ex_dst!=0 && (ex_dst==id_rs || (id_uses_rt && ex_dst==id_rt)). pc_we=0, ifid_we=0, idex_bubble=1. A pending id_jump is deferred and resolves once the stall clears.
  4. id_jump: pc_sel=2, pc_we=1, ifid_flush=1.
- Load-use stalls last exactly 1 cycle; the lw then advances out of EX.
- MEM_WAIT: freeze outputs as in RUN priority 1.
  - If dmem_ack=1: release this cycle (outputs as RUN default) and go to RUN. Branch/hazard terms are evaluated normally in this cycle.
  - Else if wait_cnt==MEM_TIMEOUT: set mem_err<=1, release as above, go to RUN.
  - Else wait_cnt increments.
- dmem_ack in the same cycle as mem_req in RUN means no wait and no state change.
- stall_cnt increments on every RUN/MEM_WAIT cycle with pc_we=0 and saturates at all-ones, with no wrap. HOLD cycles are not counted.
- Reset asserted mid-MEM_WAIT or mid-HOLD aborts immediately to HOLD and clears mem_err.

Test Plan:
- Reset for 2 cycles, then release: HOLD lasts exactly 3 cycles with pc_we=0, ifid_flush=1, busy=1. RUN starts on cycle 4, stall_cnt=0.
- ex_memread=1, ex_dst=5, id_rs=5: one cycle with pc_we=0, ifid_we=0, idex_bubble=1, stall_cnt=1. Repeat with ex_dst=0: no stall.
- ex_branch_taken=1 together with the load-use condition and id_jump=1: pc_sel=1, pc_we=1, ifid_flush=1, idex_bubble=1, no stall count.
- mem_req=1, dmem_ack=0 for 4 cycles, then ack: pipeline frozen for 4 cycles, busy=1 during MEM_WAIT, stall_cnt=4, mem_err=0.
- mem_req=1 with no ack for 20 cycles: release after cycle 16 (1 RUN + 15 MEM_WAIT), mem_err=1 and sticky until reset.
- Force stall_cnt near all-ones (CNT_W=4) and apply 20 stall cycles: stall_cnt holds at 15. Assert reset mid-MEM_WAIT: next state HOLD, mem_err=0.
